if_fetch: RTL

Instruction fetch engine: the writer side of the instruction fetch buffer. It owns the fetch PC, requests 64-bit lines from instruction memory, selects the 32-bit instruction by PC[2], and pushes {instruction, PC} into the fetch buffer one per cycle. It honours the buffer's full back-pressure and redirects on branch flush.

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_hold_reg.sv | 29 ++
 rtl/if_fetch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch engine.
package if_pkg;

  localparam int INSN_W       = 32;
  localparam int PC_W         = 64;
  localparam int LINE_W       = 64;
  localparam int WORD_SEL_BIT = 2;

  // REUSE is only reachable in builds that define IF_LINE_REUSE_EN.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    REUSE = 2'd2
  } fetch_state_t;

  // One instruction headed for the fetch buffer.
  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_hold_reg.sv
// Valid-qualified {insn, PC} register.
// Priority: reset/clear > load > pop.
module if_hold_reg
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         pop,
  input  fetch_entry_t d,
  output logic         vld,
  output fetch_entry_t q
);

  // Capture on load, drop the valid bit on pop or clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end else if (pop) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch engine: owns the fetch PC, requests 64-bit lines, picks the
// 32-bit word by PC[2] and pushes {insn, PC} into the fetch buffer.
// Optional feature macro: IF_LINE_REUSE_EN (odd word of a line pushed from
// line_buf without a second memory request).
module if_fetch
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_en_i,
  input  logic [PC_W-1:0]   flush_PC_i,
  input  logic              ifb_full_i,
  input  logic [LINE_W-1:0] Imem2proc_data_i,
  input  logic              Imem_valid_i,
  output logic              proc2Imem_req_o,
  output logic [PC_W-1:0]   proc2Imem_addr_o,
  output logic              ifb_en_o,
  output logic [INSN_W-1:0] if_insn_o,
  output logic [PC_W-1:0]   if_PC_o
);

  fetch_state_t      fstate;
  logic [PC_W-1:0]   pc;
  logic              rst_q;     // high for the cycle right after reset release
  logic              active;    // engine may request/push this cycle
  logic              push;
  logic              to_reuse;  // after pushing pc, next word comes from line_buf
  logic [INSN_W-1:0] fetch_insn;
  logic [PC_W-1:0]   pc_inc;
  fetch_entry_t      out;

  logic              hold_vld;
  fetch_entry_t      hold_q;

  assign active     = ~rst & ~rst_q & ~flush_en_i;
  assign fetch_insn = pc[WORD_SEL_BIT] ? Imem2proc_data_i[63:32] : Imem2proc_data_i[31:0];
  assign pc_inc     = pc + 64'd4;

  // Instruction captured when a hit arrives while the buffer is full.
  if_hold_reg u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush_en_i),
    .load ((fstate == FETCH) & active & Imem_valid_i & ifb_full_i),
    .pop  ((fstate == HOLD) & active & ~ifb_full_i),
    .d    ({fetch_insn, pc}),
    .vld  (hold_vld),
    .q    (hold_q)
  );

`ifdef IF_LINE_REUSE_EN
  logic         lb_vld;
  fetch_entry_t lb_q;

  assign to_reuse = ~pc[WORD_SEL_BIT];

  // line_buf: odd word of the last line returned, tagged with its PC.
  if_hold_reg u_line_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush_en_i),
    .load ((fstate == FETCH) & active & Imem_valid_i),
    .pop  ((fstate == REUSE) & active & ~ifb_full_i),
    .d    ({Imem2proc_data_i[63:32], pc[PC_W-1:3], 3'b100}),
    .vld  (lb_vld),
    .q    (lb_q)
  );
`else
  assign to_reuse = 1'b0;
`endif

  // Request and push strobes; the hit path to ifb_en_o is combinational.
  always_comb begin
    proc2Imem_req_o = 1'b0;
    push            = 1'b0;
    out             = '0;
    case (fstate)
      FETCH: begin
        proc2Imem_req_o = active;
        if (active && Imem_valid_i && !ifb_full_i) begin
          push = 1'b1;
          out  = {fetch_insn, pc};
        end
      end
      HOLD: begin
        if (active && !ifb_full_i && hold_vld) begin
          push = 1'b1;
          out  = hold_q;
        end
      end
`ifdef IF_LINE_REUSE_EN
      REUSE: begin
        if (active && !ifb_full_i && lb_vld) begin
          push = 1'b1;
          out  = lb_q;
        end
      end
`endif
      default: ;
    endcase
  end

  assign proc2Imem_addr_o = {pc[PC_W-1:3], 3'b000};
  assign ifb_en_o         = push;
  assign if_insn_o        = out.insn;
  assign if_PC_o          = out.pc;

  // PC and fetch state; flush redirects, full only ever stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q  <= 1'b1;
      fstate <= FETCH;
      pc     <= RESET_PC;
    end else begin
      rst_q <= 1'b0;
      if (flush_en_i) begin
        pc     <= flush_PC_i & ~64'h3;
        fstate <= FETCH;
      end else if (!rst_q) begin
        case (fstate)
          FETCH: begin
            if (push) begin
              pc     <= pc_inc;
              fstate <= to_reuse ? REUSE : FETCH;
            end else if (Imem_valid_i) begin
              fstate <= HOLD;
            end
          end
          HOLD: begin
            if (push) begin
              pc     <= pc_inc;
              fstate <= to_reuse ? REUSE : FETCH;
            end
          end
`ifdef IF_LINE_REUSE_EN
          REUSE: begin
            if (push) begin
              pc     <= pc_inc;
              fstate <= FETCH;
            end
          end
`endif
          default: fstate <= FETCH;
        endcase
      end
    end
  end

endmodule
